// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the signals of the shared memory port arbiter: the instruction-fetch
// requester (if_*), the load/store requester (d_*), the unified memory
// (mem_*) and the status outputs (err_o, busy_o).
//   slave  : view of the arbiter itself (requests and memory response in,
//            acks, read data, stalls and memory command out)
//   master : view of the surrounding environment (CPU datapath + memory)
// Signal suffixes (_i/_o) are relative to the arbiter.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    // Instruction-fetch requester
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_ack_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_stall_o;

    // Load/store requester
    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [BE_W-1:0]   d_be_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic              d_ack_o;
    logic [DATA_W-1:0] d_rdata_o;
    logic              d_stall_o;

    // Status
    logic              err_o;
    logic              busy_o;

    // Memory side
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [BE_W-1:0]   mem_be_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ready_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        input  d_req_i, d_we_i, d_addr_i, d_be_i, d_wdata_i,
        input  mem_ready_i, mem_rdata_i,
        output if_ack_o, if_rdata_o, if_stall_o,
        output d_ack_o, d_rdata_o, d_stall_o,
        output err_o, busy_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output d_req_i, d_we_i, d_addr_i, d_be_i, d_wdata_i,
        output mem_ready_i, mem_rdata_i,
        input  if_ack_o, if_rdata_o, if_stall_o,
        input  d_ack_o, d_rdata_o, d_stall_o,
        input  err_o, busy_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported unified memory between instruction fetch (IF) and
// load/store (D). Each access runs IDLE (arbitrate + latch) -> WAIT (memory
// command held until mem_ready_i or watchdog) -> RESP (one-cycle ack).
// D has priority; after FAIR_LIMIT consecutive D grants with IF waiting, IF
// gets the next slot. FAIR_LIMIT = 0 gives pure D priority, TIMEOUT_CYCLES = 0
// disables the watchdog.
// Ports:
//   clk_i    rising-edge clock
//   rst_n_i  asynchronous active-low reset
//   bus      mem_port_arbiter_if.slave: requester handshakes, memory command
//            and response, stalls, err_o, busy_o
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int FAIR_LIMIT     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    mem_port_arbiter_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int FW    = (FAIR_LIMIT > 0) ? $clog2(FAIR_LIMIT + 1) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam bit             FAIR_EN  = (FAIR_LIMIT != 0);
    localparam bit             TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [FW-1:0]  FAIR_MAX = FW'(FAIR_LIMIT);
    localparam logic [TMO_W-1:0] TMO_LAST =
        TMO_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic              owner_if_q,  owner_if_d;   // 1: current access belongs to IF
    logic [FW-1:0]     fair_q,      fair_d;
    logic [TMO_W-1:0]  tmo_q,       tmo_d;
    logic              if_ack_q,    if_ack_d;
    logic              d_ack_q,     d_ack_d;
    logic              err_q,       err_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [BE_W-1:0]   mem_be_q,    mem_be_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              grant_if;

    always_comb begin
        state_d     = state_q;
        owner_if_d  = owner_if_q;
        fair_d      = fair_q;
        tmo_d       = tmo_q;
        if_ack_d    = if_ack_q;
        d_ack_d     = d_ack_q;
        err_d       = err_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        // IF wins when D is idle, or when D has starved it for FAIR_LIMIT grants
        grant_if    = bus.if_req_i &
                      (~bus.d_req_i | (FAIR_EN & (fair_q == FAIR_MAX)));

        case (state_q)
            ST_IDLE: begin
                if (bus.if_req_i | bus.d_req_i) begin
                    owner_if_d = grant_if;
                    mem_req_d  = 1'b1;
                    tmo_d      = '0;
                    state_d    = ST_WAIT;
                    if (grant_if) begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.if_addr_i;
                        mem_be_d    = '1;
                        mem_wdata_d = '0;
                        fair_d      = '0;
                    end else begin
                        mem_we_d    = bus.d_we_i;
                        mem_addr_d  = bus.d_addr_i;
                        mem_be_d    = bus.d_be_i;
                        mem_wdata_d = bus.d_wdata_i;
                        if (!bus.if_req_i) begin
                            fair_d = '0;
                        end else if (fair_q != FAIR_MAX) begin
                            fair_d = fair_q + FW'(1);
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (bus.mem_ready_i) begin
                    // A ready on the watchdog cycle still counts as a normal completion
                    mem_req_d = 1'b0;
                    err_d     = 1'b0;
                    state_d   = ST_RESP;
                    if (owner_if_q) begin
                        if_rdata_d = bus.mem_rdata_i;
                        if_ack_d   = 1'b1;
                    end else begin
                        d_rdata_d  = bus.mem_rdata_i;
                        d_ack_d    = 1'b1;
                    end
                end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = ST_RESP;
                    if (owner_if_q) begin
                        if_rdata_d = '0;
                        if_ack_d   = 1'b1;
                    end else begin
                        d_rdata_d  = '0;
                        d_ack_d    = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_RESP: begin
                if_ack_d = 1'b0;
                d_ack_d  = 1'b0;
                err_d    = 1'b0;
                tmo_d    = '0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            owner_if_q  <= 1'b0;
            fair_q      <= '0;
            tmo_q       <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_if_q  <= owner_if_d;
            fair_q      <= fair_d;
            tmo_q       <= tmo_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            err_q       <= err_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.if_ack_o    = if_ack_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.if_stall_o  = bus.if_req_i & ~if_ack_q;
    assign bus.d_ack_o     = d_ack_q;
    assign bus.d_rdata_o   = d_rdata_q;
    assign bus.d_stall_o   = bus.d_req_i & ~d_ack_q;
    assign bus.err_o       = err_q;
    assign bus.busy_o      = (state_q != ST_IDLE);
    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_be_o    = mem_be_q;
    assign bus.mem_wdata_o = mem_wdata_q;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch requester (IF) and the load/store requester (D).
- Sits between the CPU datapath and the memory model.
- Sequences each access: arbitration, address/data latch, wait for memory ready, one-cycle response. Supplies stall signals to the pipeline.
- Fixed data-over-fetch priority with an anti-starvation counter; watchdog timeout on unresponsive memory.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (byte enables are DATA_W/8 wide).
- FAIR_LIMIT, 4, consecutive D grants allowed while IF waits; 0 means pure D priority.
- TIMEOUT_CYCLES, 255, WAIT cycles before forced error completion; 0 disables the timeout.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- if_req_i  in  1  fetch request; held until if_ack_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_ack_o  out  1  one-cycle fetch completion.
- if_rdata_o  out  DATA_W  fetched word; valid when if_ack_o=1.
- if_stall_o  out  1  equals if_req_i & ~if_ack_o.
- d_req_i  in  1  data request; held until d_ack_o.
- d_we_i  in  1  1 = store, 0 = load.
- d_addr_i  in  ADDR_W  data address.
- d_be_i  in  DATA_W/8  store byte enables.
- d_wdata_i  in  DATA_W  store data.
- d_ack_o  out  1  one-cycle data completion.
- d_rdata_o  out  DATA_W  load data; valid when d_ack_o=1.
- d_stall_o  out  1  equals d_req_i & ~d_ack_o.
- err_o  out  1  asserted with the ack when the access timed out.
- mem_req_o  out  1  memory access active.
- mem_we_o  out  1  memory write.
- mem_addr_o  out  ADDR_W  memory address.
- mem_be_o  out  DATA_W/8  memory byte enables.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_ready_i  in  1  memory completes the access this cycle.
- mem_rdata_i  in  DATA_W  memory read data; valid with mem_ready_i.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, rst_n_i=0):
  - State forced to IDLE.
  - All registered outputs forced to 0: acks, err_o, rdata, mem_*.
  - Fairness and timeout counters cleared.
  - Takes effect immediately, including mid-access; an interrupted access produces no ack.
- States: IDLE, WAIT, RESP.
- IDLE, arbitration on the sampled requests:
  - d_req_i=1 wins, unless if_req_i=1 and fair_cnt==FAIR_LIMIT with FAIR_LIMIT≠0; then IF wins.
  - The winner's address/we/be/wdata are latched into mem_*_o.
  - IF access drives we=0, be=all-ones, wdata=0.
  - Owner is recorded, then state → WAIT.
  - No request: remain in IDLE.
- fair_cnt:
  - Increments on a D grant while if_req_i=1, saturating at FAIR_LIMIT.
  - Clears on any IF grant.
  - Clears on a D grant with if_req_i=0.
- WAIT:
  - mem_req_o=1; latched fields held stable.
  - mem_ready_i=1: capture mem_rdata_i into the owner's rdata register, err=0, state → RESP.
  - Otherwise tmo_cnt increments. If TIMEOUT_CYCLES≠0 and tmo_cnt reaches TIMEOUT_CYCLES-1 without ready, rdata=0, err=1, state → RESP.
  - mem_ready_i on the timeout cycle counts as a normal completion.
- RESP:
  - mem_req_o=0; owner's ack_o=1 for exactly one cycle; err_o as captured.
  - Non-owner ack stays 0; requests are not sampled.
  - State → IDLE; tmo_cnt cleared.
- Latency and throughput:
  - Grant edge → mem_req_o high next cycle.
  - With mem_ready_i in the first WAIT cycle, ack arrives 2 cycles after the request was sampled.
  - Maximum throughput is one access per 3 cycles.
- Store completion: d_rdata_o is driven with the captured mem_rdata_i (don't care to the core); d_ack_o signals completion.
- Outside their ack cycle:
  - rdata outputs hold their last value.
  - err_o=0.
- Request rules:
  - Requests deasserted before ack while in WAIT/RESP do not abort the access.
  - Requester fields may change only after the ack.
- Stall outputs are combinational.

Test Plan:
- Single fetch: if_req_i=1, addr 0x10, mem_ready_i in the first WAIT cycle, rdata 0x00500093 -> if_ack_o pulses 2 cycles after the request, if_rdata_o=0x00500093, err_o=0, mem_we_o=0, mem_be_o=4'hF.
- Simultaneous requests: IF and D asserted in the same cycle, D is a store of 0xDEADBEEF with be 4'b0011 to 0x200 -> D served first with mem_we_o=1 and mem_be_o=4'b0011, then IF is served; IF is acked 3 cycles after D.
- Starvation: both requests held continuously, FAIR_LIMIT=4 -> grant order D,D,D,D,IF,D,D,D,D,IF.
- Timeout: TIMEOUT_CYCLES=8, mem_ready_i never asserted -> after 8 WAIT cycles, ack with err_o=1 and rdata=0; returns to IDLE.
- Reset mid-access: rst_n_i low during WAIT -> mem_req_o and busy_o drop immediately with no ack; after release, a fresh fetch completes normally.
- Variable latency: ready after 5 WAIT cycles -> mem_addr_o and mem_wdata_o stable for all 5 cycles; a single ack; stalls asserted for the whole access.
